// File: rtl/instruction_fetch_unit_pkg.sv
// Purpose: shared definitions for the instruction fetch stage and the
//          next-PC selector (state encodings, widths, default reset PC).
// Contents:
//   fetchState_e     FETCH / ISSUE state encoding
//   INSTR_WIDTH      instruction word width
//   ADDR_WIDTH       address width
//   J_FIELD_WIDTH    width of the J-type target field
//   DEFAULT_RESET_PC PC loaded on reset unless overridden
//   alignWord()      clears the byte-offset bits of an address
package instruction_fetch_unit_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetchState_e;

  localparam int INSTR_WIDTH   = 32;
  localparam int ADDR_WIDTH    = 32;
  localparam int J_FIELD_WIDTH = 26;

  localparam logic [ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0040_0000;

  function automatic logic [ADDR_WIDTH-1:0] alignWord(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_next_pc_select.sv
// Purpose: combinational next-PC selection for a MIPS-style datapath.
//          Shared by the fetch unit and the single-cycle datapath.
// Ports:
//   pcPlus4    in  32  address of the sequential successor
//   jField     in  26  instruction[25:0], J-type target field
//   branchImm  in  32  sign-extended 16-bit branch offset (in words)
//   jump       in  1   J-type instruction
//   branchEq   in  1   BEQ instruction
//   branchNe   in  1   BNE instruction
//   zero       in  1   ALU zero flag
//   nextPc     out 32  selected next PC
module next_pc_select
  import instruction_fetch_unit_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0]    pcPlus4,
  input  logic [J_FIELD_WIDTH-1:0] jField,
  input  logic [ADDR_WIDTH-1:0]    branchImm,
  input  logic                     jump,
  input  logic                     branchEq,
  input  logic                     branchNe,
  input  logic                     zero,
  output logic [ADDR_WIDTH-1:0]    nextPc
);

  logic branchTaken;

  // With both branch flags set the OR below is always true, which is the
  // intended "always taken" behaviour. Jump wins over any branch.
  always_comb begin
    branchTaken = (branchEq & zero) | (branchNe & ~zero);
    if (jump) begin
      nextPc = {pcPlus4[ADDR_WIDTH-1:ADDR_WIDTH-4], jField, 2'b00};
    end else if (branchTaken) begin
      nextPc = pcPlus4 + (branchImm << 2);
    end else begin
      nextPc = pcPlus4;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Purpose: fetch stage in front of the MIPS control unit. Holds the PC,
//          fetches over a req/ack handshake, presents the instruction with
//          valid/ready and picks the next PC when the instruction retires.
// Ports:
//   clk          in  1          rising-edge clock
//   reset        in  1          asynchronous active-high reset
//   imem_req     out 1          fetch request
//   imem_addr    out 32         fetch address (= pc)
//   imem_ack     in  1          memory ack, imem_rdata valid same cycle
//   imem_rdata   in  32         fetched word
//   instruction  out 32         registered instruction
//   instr_valid  out 1          instruction valid
//   instr_ready  in  1          consumer retires instruction this cycle
//   jump         in  1          J-type from control
//   branch_eq    in  1          BEQ from control
//   branch_ne    in  1          BNE from control
//   zero         in  1          ALU zero flag
//   branch_imm   in  32         sign-extended immediate
//   pc           out 32         PC of current instruction
//   pc_plus4     out 32         pc + 4
//   instr_count  out CNT_WIDTH  retired instructions since reset
//
// state | meaning
// FETCH | request outstanding at pc, waiting for imem_ack
// ISSUE | instruction held valid, waiting for instr_ready
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            instruction,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   jump,
  input  logic                   branch_eq,
  input  logic                   branch_ne,
  input  logic                   zero,
  input  logic [31:0]            branch_imm,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic [CNT_WIDTH-1:0]   instr_count
);

  fetchState_e      state;
  fetchState_e      nextState;
  logic             loadInstr;
  logic             retire;
  logic [31:0]      nextPc;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  next_pc_select uNextPcSelect (
    .pcPlus4   (pc_plus4),
    .jField    (instruction[J_FIELD_WIDTH-1:0]),
    .branchImm (branch_imm),
    .jump      (jump),
    .branchEq  (branch_eq),
    .branchNe  (branch_ne),
    .zero      (zero),
    .nextPc    (nextPc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      FETCH:   if (loadInstr) nextState = ISSUE;
      ISSUE:   if (retire)    nextState = FETCH;
      default: nextState = FETCH;
    endcase
  end

  // An ack only counts while the request is actually up, so a stray ack in
  // the first cycle after reset is dropped. Ready only counts in ISSUE.
  always_comb begin
    loadInstr = (state == FETCH) & imem_req & imem_ack;
    retire    = (state == ISSUE) & instr_ready;
  end

  // imem_req and instr_valid are registered copies of the upcoming state,
  // so the request rises on the first edge after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= alignWord(RESET_PC);
      instruction <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      instr_count <= '0;
    end else begin
      imem_req    <= (nextState == FETCH);
      instr_valid <= (nextState == ISSUE);
      if (loadInstr) begin
        instruction <= imem_rdata;
      end
      if (retire) begin
        pc          <= alignWord(nextPc);
        instr_count <= instr_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
